// File: rtl/subservient_wb_timer.sv
// subservient_wb_timer: Wishbone machine timer for the subservient peripheral bus.
// MTIME counter with prescaler, MTIMECMP compare and a registered timer irq.
// Optional build macro: SUBSERVIENT_TIMER_64_EN widens MTIME/MTIMECMP to 64 bits
// and maps the upper halves at word indices 4 (MTIMEH) and 5 (MTIMECMPH).
module subservient_wb_timer #(
  parameter int          PRESCALE_W = 8,
  parameter logic [31:0] CMP_RESET  = 32'hFFFFFFFF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_timer_irq
);

`ifdef SUBSERVIENT_TIMER_64_EN
  localparam int          TW       = 64;
  localparam logic [63:0] CMP_INIT = {32'hFFFFFFFF, CMP_RESET};
`else
  localparam int          TW       = 32;
  localparam logic [31:0] CMP_INIT = CMP_RESET;
`endif

  // Replace the selected byte lanes of old_v with new_v.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  logic                  ack_q;
  logic [31:0]           rdt_q, rdt_d;
  logic                  irq_q, irq_d;
  logic [TW-1:0]         mtime_q, mtime_d;
  logic [TW-1:0]         cmp_q, cmp_d;
  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  logic                  access;
  logic                  wr;
  logic [2:0]            idx;
  logic                  wr_mtime_lo, wr_cmp_lo, wr_ctrl;
  logic                  wr_mtime_any;
  logic                  tick;
  logic [31:0]           ctrl_rd;
  logic [PRESCALE_W-1:0] pre_wr;
  logic                  unused_adr;

  // A new access is one where stb is seen while ack is not already high.
  // A write with no byte lanes selected is treated as no write at all,
  // so it neither changes registers nor disturbs the prescaler.
  assign access      = i_wb_stb & ~ack_q;
  assign wr          = access & i_wb_we & (|i_wb_sel);
  assign idx         = i_wb_adr[4:2];
  assign wr_mtime_lo = wr && (idx == 3'd0);
  assign wr_cmp_lo   = wr && (idx == 3'd1);
  assign wr_ctrl     = wr && (idx == 3'd2);
  assign tick        = en_q && (cnt_q == pre_q);
  assign unused_adr  = ^{i_wb_adr[31:5], i_wb_adr[1:0]};

`ifdef SUBSERVIENT_TIMER_64_EN
  logic wr_mtime_hi, wr_cmp_hi;
  assign wr_mtime_hi  = wr && (idx == 3'd4);
  assign wr_cmp_hi    = wr && (idx == 3'd5);
  assign wr_mtime_any = wr_mtime_lo | wr_mtime_hi;
`else
  assign wr_mtime_any = wr_mtime_lo;
`endif

  // PRE field lives at bits [8+PRESCALE_W-1:8]; each bit follows its byte lane.
  for (genvar gi = 0; gi < PRESCALE_W; gi++) begin : g_pre_bits
    assign pre_wr[gi] = i_wb_sel[(8 + gi) / 8] ? i_wb_dat[8 + gi] : pre_q[gi];
  end

  // CTRL read view: EN in bit 0, PRE above bit 8, everything else zero.
  always_comb begin
    ctrl_rd                  = '0;
    ctrl_rd[0]               = en_q;
    ctrl_rd[8 +: PRESCALE_W] = pre_q;
  end

  // Next-state for control, prescaler, counter, compare, irq and read data.
  always_comb begin
    en_d    = en_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    mtime_d = mtime_q;
    cmp_d   = cmp_q;
    rdt_d   = rdt_q;
    irq_d   = (mtime_q >= cmp_q);

    if (wr_ctrl) begin
      en_d  = i_wb_sel[0] ? i_wb_dat[0] : en_q;
      pre_d = pre_wr;
    end

    // Prescale counter restarts on any CTRL write so a new divisor takes
    // effect from a known phase.
    if (wr_ctrl) begin
      cnt_d = '0;
    end else if (en_q) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    // A software write to the counter wins over a coincident tick.
    if (wr_mtime_any) begin
      if (wr_mtime_lo) mtime_d[31:0] = byte_merge(mtime_q[31:0], i_wb_dat, i_wb_sel);
`ifdef SUBSERVIENT_TIMER_64_EN
      if (wr_mtime_hi) mtime_d[63:32] = byte_merge(mtime_q[63:32], i_wb_dat, i_wb_sel);
`endif
    end else if (tick) begin
      mtime_d = mtime_q + 1'b1;
    end

    if (wr_cmp_lo) cmp_d[31:0] = byte_merge(cmp_q[31:0], i_wb_dat, i_wb_sel);
`ifdef SUBSERVIENT_TIMER_64_EN
    if (wr_cmp_hi) cmp_d[63:32] = byte_merge(cmp_q[63:32], i_wb_dat, i_wb_sel);
`endif

    if (access) begin
      case (idx)
        3'd0:    rdt_d = mtime_q[31:0];
        3'd1:    rdt_d = cmp_q[31:0];
        3'd2:    rdt_d = ctrl_rd;
        3'd3:    rdt_d = {31'b0, irq_q};
`ifdef SUBSERVIENT_TIMER_64_EN
        3'd4:    rdt_d = mtime_q[63:32];
        3'd5:    rdt_d = cmp_q[63:32];
`endif
        default: rdt_d = 32'h0;
      endcase
    end
  end

  // State registers; reset aborts any in-flight access.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ack_q   <= 1'b0;
      rdt_q   <= 32'h0;
      irq_q   <= 1'b0;
      mtime_q <= '0;
      cmp_q   <= CMP_INIT;
      en_q    <= 1'b0;
      pre_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ack_q   <= access;
      rdt_q   <= rdt_d;
      irq_q   <= irq_d;
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      pre_q   <= pre_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_wb_ack    = ack_q;
  assign o_wb_rdt    = rdt_q;
  assign o_timer_irq = irq_q;

endmodule

// File: tb/tb_subservient_wb_timer.sv
// Randomized bench for subservient_wb_timer (default 32-bit build).
// The reference model describes MTIME arithmetically: a base value valid at
// some clock edge plus the number of prescaler periods elapsed since the last
// CTRL write, so no per-cycle counter is replicated.
module tb_subservient_wb_timer;

  localparam logic [31:0] CTRL_MASK = 32'h0000FF01;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic        we, stb;
  logic [31:0] rdt;
  logic        ack, irq;

  always #5 clk = ~clk;

  subservient_wb_timer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wb_adr    (adr),
    .i_wb_dat    (dat),
    .i_wb_sel    (sel),
    .i_wb_we     (we),
    .i_wb_stb    (stb),
    .o_wb_rdt    (rdt),
    .o_wb_ack    (ack),
    .o_timer_irq (irq)
  );

  int errors = 0;
  int checks = 0;
  longint cyc = 0;

  // Reference model state.
  logic [31:0] m_ref;        // MTIME value after edge m_ref_edge
  longint      m_ref_edge;
  longint      m_ctrl_edge;  // edge of last CTRL write (prescaler phase origin)
  logic [31:0] m_ctrl;
  logic [31:0] m_cmp;
  bit          exp_irq;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // MTIME after edge t: ticks land on edges m_ctrl_edge + k*(PRE+1), k >= 1.
  function automatic logic [31:0] mtime_at(input longint t);
    longint per, n;
    if (!m_ctrl[0]) return m_ref;
    per = longint'(m_ctrl[15:8]) + 1;
    n = (t - m_ctrl_edge) / per - (m_ref_edge - m_ctrl_edge) / per;
    return m_ref + 32'(n);
  endfunction

  task automatic model_reset();
    m_ref       = 32'h0;
    m_ref_edge  = cyc;
    m_ctrl_edge = cyc;
    m_ctrl      = 32'h0;
    m_cmp       = 32'hFFFFFFFF;
    exp_irq     = 1'b0;
  endtask

  // Advance one clock; irq after this edge reflects compare of the state before it.
  task automatic tick();
    bit e;
    e = (mtime_at(cyc) >= m_cmp);
    @(posedge clk);
    #1;
    cyc++;
    exp_irq = e;
    check_val("irq", {31'b0, irq}, {31'b0, e});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One complete access: stb for one edge, ack checked high then low.
  task automatic bus(input logic [2:0] idx, input bit wr, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    logic [31:0] exp_rd;
    adr = {27'b0, idx, 2'b00};
    dat = d;
    sel = s;
    we  = wr;
    stb = 1'b1;
    check_val("ack_idle", {31'b0, ack}, 32'h0);
    case (idx)
      3'd0:    exp_rd = mtime_at(cyc);
      3'd1:    exp_rd = m_cmp;
      3'd2:    exp_rd = m_ctrl;
      3'd3:    exp_rd = {31'b0, exp_irq};
      default: exp_rd = 32'h0;
    endcase
    tick();
    check_val("ack", {31'b0, ack}, 32'h1);
    rd = rdt;
    if (!wr) begin
      check_val($sformatf("rd%0d", idx), rdt, exp_rd);
      $display("read  idx=%0d data=%h", idx, rdt);
    end else begin
      if (s != 4'b0) begin
        case (idx)
          3'd0: begin
            m_ref      = merge(exp_rd, d, s);
            m_ref_edge = cyc;
          end
          3'd1: m_cmp = merge(m_cmp, d, s);
          3'd2: begin
            m_ref       = mtime_at(cyc);
            m_ref_edge  = cyc;
            m_ctrl      = merge(m_ctrl, d, s) & CTRL_MASK;
            m_ctrl_edge = cyc;
          end
          default: ;
        endcase
      end
      $display("write idx=%0d data=%h sel=%b", idx, d, s);
    end
    stb = 1'b0;
    we  = 1'b0;
    tick();
    check_val("ack_drop", {31'b0, ack}, 32'h0);
  endtask

  logic [31:0] r, r1, r2;

  initial begin
    rst = 1'b1; adr = '0; dat = '0; sel = '0; we = 1'b0; stb = 1'b0;
    model_reset();
    idle(3);
    rst = 1'b0;
    model_reset();
    idle(1);

    // Reset values.
    bus(3'd0, 0, 0, 4'hF, r);
    bus(3'd1, 0, 0, 4'hF, r); check_val("cmp_reset", r, 32'hFFFFFFFF);
    bus(3'd2, 0, 0, 4'hF, r);
    bus(3'd3, 0, 0, 4'hF, r);

    // Ack never high two cycles in a row with stb held.
    adr = 32'h4; we = 1'b0; sel = 4'hF; stb = 1'b1;
    tick(); check_val("hold_ack1", {31'b0, ack}, 32'h1);
    tick(); check_val("hold_ack2", {31'b0, ack}, 32'h0);
    tick(); check_val("hold_ack3", {31'b0, ack}, 32'h1);
    check_val("hold_rd", rdt, m_cmp);
    stb = 1'b0;
    tick(); check_val("hold_ack4", {31'b0, ack}, 32'h0);

    // Free running, PRE=0 then PRE=3.
    bus(3'd2, 1, 32'h0000_0001, 4'hF, r);
    idle(10);
    bus(3'd0, 0, 0, 4'hF, r1);
    bus(3'd0, 0, 0, 4'hF, r2);
    check_val("rate1", r2 - r1, 32'd2);
    bus(3'd2, 1, 32'h0000_0301, 4'hF, r);
    bus(3'd2, 0, 0, 4'hF, r);
    idle(13);
    bus(3'd0, 0, 0, 4'hF, r);

    // Compare: irq at MTIME=20, cleared by raising MTIMECMP.
    bus(3'd2, 1, 32'h0, 4'hF, r);
    bus(3'd0, 1, 32'h0, 4'hF, r);
    bus(3'd1, 1, 32'd20, 4'hF, r);
    bus(3'd2, 1, 32'h1, 4'hF, r);
    idle(25);
    bus(3'd3, 0, 0, 4'hF, r); check_val("status_hi", r, 32'h1);
    bus(3'd1, 1, 32'd100, 4'hF, r);
    bus(3'd3, 0, 0, 4'hF, r); check_val("status_lo", r, 32'h0);

    // Wrap past MTIMECMP.
    bus(3'd2, 1, 32'h0, 4'hF, r);
    bus(3'd0, 1, 32'hFFFFFFFE, 4'hF, r);
    bus(3'd1, 1, 32'hFFFFFFFF, 4'hF, r);
    bus(3'd2, 1, 32'h1, 4'hF, r);
    idle(6);
    bus(3'd3, 0, 0, 4'hF, r);

    // Byte lanes, unmapped, sel=0.
    bus(3'd1, 1, 32'h11223344, 4'hF, r);
    bus(3'd1, 1, 32'hAABBCCDD, 4'b0010, r);
    bus(3'd1, 0, 0, 4'hF, r); check_val("byte_merge", r, 32'h1122CC44);
    bus(3'd6, 0, 0, 4'hF, r); check_val("unmapped", r, 32'h0);
    bus(3'd6, 1, 32'hDEADBEEF, 4'hF, r);
    bus(3'd1, 1, 32'h0, 4'h0, r);
    bus(3'd1, 0, 0, 4'hF, r); check_val("sel0", r, 32'h1122CC44);

    // Write to MTIME on a tick cycle wins (PRE=0 ticks every cycle).
    bus(3'd0, 1, 32'd5, 4'hF, r);
    bus(3'd0, 0, 0, 4'hF, r); check_val("mtime_wins", r, 32'd6);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      logic [2:0]  i;
      bit          w;
      logic [31:0] d;
      logic [3:0]  s;
      i = 3'($urandom_range(0, 7));
      w = ($urandom_range(0, 1) == 1);
      d = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      if (i == 3'd2) d = {d[31:16], 8'($urandom_range(0, 3)), d[7:1], 1'($urandom_range(0, 3) != 0)};
      if (i == 3'd1) d = mtime_at(cyc) + 32'($urandom_range(0, 40)) - 32'd10;
      if (i == 3'd0 && $urandom_range(0, 1) == 1) d = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      bus(i, w, d, s, r);
      idle($urandom_range(0, 3));
    end

    // Reset in the middle of a pending write.
    adr = 32'h4; dat = 32'h12345678; sel = 4'hF; we = 1'b1; stb = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_val("rst_ack", {31'b0, ack}, 32'h0);
    check_val("rst_irq", {31'b0, irq}, 32'h0);
    idle(2);
    check_val("rst_ack_hold", {31'b0, ack}, 32'h0);
    stb = 1'b0; we = 1'b0;
    rst = 1'b0;
    model_reset();
    tick();
    check_val("post_rst_ack", {31'b0, ack}, 32'h0);
    bus(3'd0, 0, 0, 4'hF, r); check_val("post_rst_mtime", r, 32'h0);
    bus(3'd1, 0, 0, 4'hF, r); check_val("post_rst_cmp", r, 32'hFFFFFFFF);
    bus(3'd2, 0, 0, 4'hF, r); check_val("post_rst_ctrl", r, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
